// File: rtl/sb_reg_access_ctrl.sv
// Sideband register-access responder.
// Parses command frames (addr, {rw,len}, data...) from the sideband byte
// receiver, drives the register file strobes and serializes a response frame
// back to the sideband transmitter.
module sb_reg_access_ctrl #(
  parameter int MAX_ADDR = 156,
  parameter int TIMEOUT  = 1024
) (
  input  logic        fsm_clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        s_read,
  output logic        s_write,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  input  logic [23:0] sb_read,
  output logic        busy,
  output logic        rx_drop,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0]    ADDR_MAX9 = 9'(MAX_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_DRAIN,
    ST_READ,
    ST_RWAIT,
    ST_RESP
  } state_t;

  state_t        state_reg;
  logic [7:0]    addr_reg;
  logic          rw_reg;
  logic [6:0]    len_reg;
  logic [6:0]    idx_reg;
  logic          status_reg;
  logic [23:0]   rdata_reg;
  logic [TW-1:0] tout_reg;
  logic [2:0]    resp_idx_reg;
  logic [2:0]    resp_last_reg;

  // Header decode straight from the incoming byte so the legality decision
  // is made in the same cycle the header arrives.
  logic       hdr_rw;
  logic [6:0] hdr_len;
  logic [8:0] wr_end;
  logic [8:0] rd_end;
  logic       wr_ok;
  logic       rd_ok;

  assign hdr_rw  = rx_byte[7];
  assign hdr_len = rx_byte[6:0];
  assign wr_end  = {1'b0, addr_reg} + {2'b00, hdr_len} - 9'd1;
  assign rd_end  = {1'b0, addr_reg} + 9'd2;
  assign wr_ok   = hdr_rw && (hdr_len != 7'd0) && (wr_end <= ADDR_MAX9);
  assign rd_ok   = !hdr_rw && (hdr_len == 7'd3) && (rd_end <= ADDR_MAX9);

  assign busy = (state_reg != ST_IDLE);

  // Response byte following the one currently presented on tx_byte.
  logic [2:0] sel_idx;
  logic [7:0] sel_byte;

  assign sel_idx = resp_idx_reg + 3'd1;

  // Select the next response byte: addr, {rw,len}, status, then read data LSB first.
  always_comb begin
    sel_byte = addr_reg;
    case (sel_idx)
      3'd1:    sel_byte = {rw_reg, len_reg};
      3'd2:    sel_byte = {7'd0, status_reg};
      3'd3:    sel_byte = rdata_reg[7:0];
      3'd4:    sel_byte = rdata_reg[15:8];
      3'd5:    sel_byte = rdata_reg[23:16];
      default: sel_byte = addr_reg;
    endcase
  end

  // Frame FSM with registered strobes, response serializer and inter-byte timeout.
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      rw_reg        <= 1'b0;
      len_reg       <= '0;
      idx_reg       <= '0;
      status_reg    <= 1'b0;
      rdata_reg     <= '0;
      tout_reg      <= '0;
      resp_idx_reg  <= '0;
      resp_last_reg <= '0;
      tx_byte       <= '0;
      tx_valid      <= 1'b0;
      s_read        <= 1'b0;
      s_write       <= 1'b0;
      s_address     <= '0;
      s_data        <= '0;
      rx_drop       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      s_read      <= 1'b0;
      s_write     <= 1'b0;
      rx_drop     <= 1'b0;
      err_timeout <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          tout_reg <= '0;
          if (rx_valid) begin
            addr_reg  <= rx_byte;
            state_reg <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (rx_valid) begin
            tout_reg <= '0;
            rw_reg   <= hdr_rw;
            len_reg  <= hdr_len;
            idx_reg  <= '0;
            if (hdr_rw) begin
              resp_last_reg <= 3'd2;
              if (wr_ok) begin
                status_reg <= 1'b0;
                state_reg  <= ST_WDATA;
              end else if (hdr_len == 7'd0) begin
                // Nothing to drain: answer with the error status right away.
                status_reg   <= 1'b1;
                state_reg    <= ST_RESP;
                tx_byte      <= addr_reg;
                tx_valid     <= 1'b1;
                resp_idx_reg <= '0;
              end else begin
                status_reg <= 1'b1;
                state_reg  <= ST_DRAIN;
              end
            end else if (rd_ok) begin
              status_reg    <= 1'b0;
              resp_last_reg <= 3'd5;
              s_read        <= 1'b1;
              s_address     <= addr_reg;
              state_reg     <= ST_READ;
            end else begin
              status_reg    <= 1'b1;
              resp_last_reg <= 3'd2;
              state_reg     <= ST_RESP;
              tx_byte       <= addr_reg;
              tx_valid      <= 1'b1;
              resp_idx_reg  <= '0;
            end
          end
        end

        ST_WDATA: begin
          if (rx_valid) begin
            tout_reg  <= '0;
            s_write   <= 1'b1;
            s_address <= addr_reg + {1'b0, idx_reg};
            s_data    <= rx_byte;
            idx_reg   <= idx_reg + 7'd1;
            if (idx_reg == len_reg - 7'd1) begin
              state_reg    <= ST_RESP;
              tx_byte      <= addr_reg;
              tx_valid     <= 1'b1;
              resp_idx_reg <= '0;
            end
          end
        end

        ST_DRAIN: begin
          if (rx_valid) begin
            tout_reg <= '0;
            idx_reg  <= idx_reg + 7'd1;
            if (idx_reg == len_reg - 7'd1) begin
              state_reg    <= ST_RESP;
              tx_byte      <= addr_reg;
              tx_valid     <= 1'b1;
              resp_idx_reg <= '0;
            end
          end
        end

        ST_READ: begin
          // s_read is high this cycle; the file registers the data on this edge.
          state_reg <= ST_RWAIT;
        end

        ST_RWAIT: begin
          rdata_reg    <= sb_read;
          state_reg    <= ST_RESP;
          tx_byte      <= addr_reg;
          tx_valid     <= 1'b1;
          resp_idx_reg <= '0;
        end

        ST_RESP: begin
          if (tx_valid && tx_ready) begin
            if (resp_idx_reg == resp_last_reg) begin
              tx_valid  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              resp_idx_reg <= sel_idx;
              tx_byte      <= sel_byte;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase

      // Bytes arriving while the responder cannot consume them are discarded.
      if (rx_valid && ((state_reg == ST_READ) || (state_reg == ST_RWAIT) ||
                       (state_reg == ST_RESP))) begin
        rx_drop <= 1'b1;
      end

      // Inter-byte timeout inside a frame; an rx byte in the final cycle wins.
      if (((state_reg == ST_HDR) || (state_reg == ST_WDATA) ||
           (state_reg == ST_DRAIN)) && !rx_valid) begin
        if (tout_reg == TOUT_LAST) begin
          err_timeout <= 1'b1;
          tout_reg    <= '0;
          state_reg   <= ST_IDLE;
        end else begin
          tout_reg <= tout_reg + TW'(1);
        end
      end
    end
  end

endmodule
